// File: rtl/timer_mc.sv
`default_nettype none
// ============================================================================
// timer_mc : shared prescaler feeding NUM_CH compare channels, level IRQ out
// Rev 1.0
// ============================================================================
module timer_mc #(
   parameter int NUM_CH  = 4,
   parameter int COUNT_W = 32,
   parameter int PRESC_W = 11
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        intr_o
);
   localparam logic [1:0] C_OFF_CTRL  = 2'd0;
   localparam logic [1:0] C_OFF_COUNT = 2'd1;
   localparam logic [1:0] C_OFF_CMP   = 2'd2;
   localparam logic [1:0] C_OFF_STAT  = 2'd2;
   localparam logic [1:0] C_OFF_IRQEN = 2'd3;
   localparam logic [1:0] C_OFF_GCTRL = 2'd1;
   localparam logic [1:0] C_OFF_PRESC = 2'd0;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic               gen_q, gen_d;
   logic               tick_q, tick_d;
   logic [NUM_CH-1:0]  status_q, status_d;
   logic [NUM_CH-1:0]  irq_en_q, irq_en_d;
   logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
   logic [NUM_CH-1:0]  oneshot_q, oneshot_d;
   logic [COUNT_W-1:0] count_q [NUM_CH];
   logic [COUNT_W-1:0] count_d [NUM_CH];
   logic [COUNT_W-1:0] cmp_q [NUM_CH];
   logic [COUNT_W-1:0] cmp_d [NUM_CH];
   logic [31:0]        readdata_q, readdata_d;

   logic               wr_en;
   logic               rd_en;
   logic [2:0]         slot;
   logic [1:0]         offs;
   logic [NUM_CH-1:0]  ch_sel;
   logic [NUM_CH-1:0]  event_w;
   logic [31:0]        rdata_w;

   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;
   assign slot  = address[4:2];
   assign offs  = address[1:0];

   // Slot 0 holds the global registers; channel n lives in slot n+1.
   always_comb begin
      ch_sel = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         ch_sel[n] = (slot == 3'(n + 1));
      end
   end

   // Divider wraps on >= so a PRESC lowered mid-count cannot run away.
   always_comb begin
      div_d  = '0;
      tick_d = 1'b0;
      if (gen_q) begin
         div_d  = (div_q >= presc_q) ? '0 : div_q + PRESC_W'(1);
         tick_d = (div_q == presc_q) & ~stall_i;
      end
   end

   always_comb begin
      ch_en_d   = ch_en_q;
      oneshot_d = oneshot_q;
      event_w   = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         count_d[n] = count_q[n];
         cmp_d[n]   = cmp_q[n];
         if (tick_q && ch_en_q[n] &&
             !(wr_en && ch_sel[n] && (offs == C_OFF_CTRL || offs == C_OFF_COUNT))) begin
            if (cmp_q[n] == '0) begin
               count_d[n] = '0;
            end else if (count_q[n] == cmp_q[n]) begin
               count_d[n] = '0;
               event_w[n] = 1'b1;
               if (oneshot_q[n]) begin
                  ch_en_d[n] = 1'b0;
               end
            end else begin
               count_d[n] = count_q[n] + COUNT_W'(1);
            end
         end
         if (wr_en && ch_sel[n]) begin
            case (offs)
               C_OFF_CTRL: begin
                  ch_en_d[n]   = writedata[0];
                  oneshot_d[n] = writedata[1];
               end
               C_OFF_COUNT: count_d[n] = writedata[COUNT_W-1:0];
               C_OFF_CMP:   cmp_d[n]   = writedata[COUNT_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // A flag raised this cycle survives a simultaneous W1C.
   always_comb begin
      presc_d  = presc_q;
      gen_d    = gen_q;
      irq_en_d = irq_en_q;
      status_d = status_q;
      if (wr_en && slot == 3'd0) begin
         case (offs)
            C_OFF_PRESC: presc_d  = writedata[PRESC_W-1:0];
            C_OFF_GCTRL: gen_d    = writedata[0];
            C_OFF_STAT:  status_d = status_q & ~writedata[NUM_CH-1:0];
            C_OFF_IRQEN: irq_en_d = writedata[NUM_CH-1:0];
            default: ;
         endcase
      end
      status_d = status_d | event_w;
   end

   always_comb begin
      rdata_w = '0;
      if (slot == 3'd0) begin
         case (offs)
            C_OFF_PRESC: rdata_w[PRESC_W-1:0] = presc_q;
            C_OFF_GCTRL: rdata_w[0]           = gen_q;
            C_OFF_STAT:  rdata_w[NUM_CH-1:0]  = status_q;
            C_OFF_IRQEN: rdata_w[NUM_CH-1:0]  = irq_en_q;
            default: ;
         endcase
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (ch_sel[n]) begin
               case (offs)
                  C_OFF_CTRL: begin
                     rdata_w[0] = ch_en_q[n];
                     rdata_w[1] = oneshot_q[n];
                  end
                  C_OFF_COUNT: rdata_w[COUNT_W-1:0] = count_q[n];
                  C_OFF_CMP:   rdata_w[COUNT_W-1:0] = cmp_q[n];
                  default: ;
               endcase
            end
         end
      end
      readdata_d = rd_en ? rdata_w : readdata_q;
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         div_q      <= '0;
         gen_q      <= 1'b0;
         tick_q     <= 1'b0;
         status_q   <= '0;
         irq_en_q   <= '0;
         ch_en_q    <= '0;
         oneshot_q  <= '0;
         readdata_q <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            count_q[n] <= '0;
            cmp_q[n]   <= '0;
         end
      end else begin
         presc_q    <= presc_d;
         div_q      <= div_d;
         gen_q      <= gen_d;
         tick_q     <= tick_d;
         status_q   <= status_d;
         irq_en_q   <= irq_en_d;
         ch_en_q    <= ch_en_d;
         oneshot_q  <= oneshot_d;
         readdata_q <= readdata_d;
         for (int n = 0; n < NUM_CH; n++) begin
            count_q[n] <= count_d[n];
            cmp_q[n]   <= cmp_d[n];
         end
      end
   end

   assign readdata = readdata_q;
   assign intr_o   = |(status_q & irq_en_q);

endmodule
`default_nettype wire

// File: doc/timer_mc.md
# timer_mc

Multi-channel, parametrised successor to the single-channel uncore timer. One shared prescaler drives NUM_CH independent compare channels. Each channel runs in periodic or one-shot mode and has its own event flag and interrupt enable. The block sits on the uncore memory-mapped bus and drives one level-sensitive interrupt line to the core's interrupt controller.

## Interface
Parameters:
- NUM_CH, 4, number of channels (1..4)
- COUNT_W, 32, channel count/compare width (8..32)
- PRESC_W, 11, prescaler width (1..16)

Ports:
- clk_i  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- stall_i  in  1  core stall; suppresses counting ticks while high
- chipselect  in  1  block select
- read  in  1  read strobe (qualified by chipselect)
- write  in  1  write strobe (qualified by chipselect)
- address  in  5  word address
- writedata  in  32  write data
- readdata  out  32  registered read data
- intr_o  out  1  level interrupt, OR of (irq_status & irq_en)

## Operation
Register map (word addresses; unused bits read 0, writes to unmapped addresses are ignored, reads return 0):
- 0 PRESC: [PRESC_W-1:0] divide value
- 1 GCTRL: bit0 global enable
- 2 IRQ_STATUS: [NUM_CH-1:0] sticky event flags; write-1-to-clear
- 3 IRQ_EN: [NUM_CH-1:0] per-channel interrupt enable
- 4+4n CTRL_n: bit0 ch_en, bit1 oneshot (0 = periodic)
- 5+4n COUNT_n: [COUNT_W-1:0], read/write
- 6+4n CMP_n: [COUNT_W-1:0]
- 7+4n: reserved, reads 0
- Channel addresses for n >= NUM_CH are unmapped.

Prescaler:
- Divider counts 0..PRESC while GCTRL.en = 1, then returns to 0. It holds at 0 while disabled.
- tick is registered: tick <= GCTRL.en & (divider == PRESC) & ~stall_i. With PRESC = 0, tick asserts every cycle.
- tick drives all channels simultaneously.

Channel n, on a cycle with tick & ch_en:
- If CMP_n == 0: COUNT_n stays 0 and no event is raised.
- Else if COUNT_n == CMP_n: COUNT_n <= 0 and IRQ_STATUS[n] is set. In oneshot mode, ch_en is also cleared in the same cycle.
- Else: COUNT_n <= COUNT_n + 1, modulo 2^COUNT_W. If COUNT_n was written above CMP_n, it wraps through all-ones to 0 with no event at the wrap.

Priorities:
- A bus write to COUNT_n or CTRL_n in the same cycle as a tick wins; that tick is lost for that channel.
- An event set and a W1C clear of the same IRQ_STATUS bit in the same cycle: set wins.

Reset values: all registers 0, divider 0, tick 0, readdata 0, intr_o 0.

## Timing
- Read: readdata is updated on the clock edge where read & chipselect is sampled, one cycle of latency. It holds its value otherwise.
- Writes take effect on the sampling edge and are visible to a read issued the following cycle.
- Tick cadence: one tick every PRESC+1 cycles, first tick arrives PRESC+2 cycles after GCTRL.en is written 1.
  - A stall_i-high cycle drops the tick for that period; the divider keeps running, so ticks are not deferred.
- Event to interrupt: IRQ_STATUS[n] sets on the tick edge where COUNT_n == CMP_n. intr_o (combinational from registers) rises in that same cycle if IRQ_EN[n] = 1.
  - intr_o stays high until the flag is cleared by W1C or IRQ_EN is cleared.
- Period: (CMP+1)·(PRESC+1) cycles per event in periodic mode.
- Clearing GCTRL.en resets the divider to 0 on the next edge. Channel COUNT and CTRL values are preserved.
- Asserting reset mid-count returns all state to reset values immediately; intr_o drops asynchronously.

## Test plan
- PRESC=3, CMP_0=4, periodic, IRQ_EN=1, GCTRL=1 → IRQ_STATUS[0] sets every 20 cycles. Write IRQ_STATUS=1 → intr_o low the next cycle. The next event re-asserts it.
- Channel 1 oneshot, CMP=2, PRESC=0 → a single event at the 3rd tick. CTRL_1 reads 0x2 afterwards. COUNT_1 stays 0 with no further events.
- Channels 0–3 with CMP = 1, 2, 3, 0 and PRESC=0 → events at periods 2, 3, 4 ticks. Channel 3 never flags. intr_o reflects only enabled channels.
- Hold stall_i high for 2 of every 4 cycles with PRESC=0 → COUNT advances only on non-stall ticks. Check no burst catch-up.
- W1C of bit 0 on the exact cycle an event sets it → bit remains 1. Write COUNT_0=0xFFFF_FFFE with CMP_0=5 → wraps to 0, no event, then an event at 5.
- Assert reset mid-count (COUNT_2=7) → all registers read 0, intr_o 0. Read of address 31 returns 0.
